// File: rtl/bus_arbiter_pkg.sv
// Shared types and header helpers for the bus-lane arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, POP, PUSH} arb_state_t;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned MAX_PKT_W = 1024;

  // Destination ID sits in the top ID_W bits of a pkt_w-bit packet.
  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                input int unsigned          pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Driver-side handshake of one bus lane: pending/pop from the FIFOs, push into the drivers.
interface bus_arbiter_if #(
  parameter int unsigned PCKG_SZ = 16,
  parameter int unsigned DRVRS   = 4
);

  localparam int unsigned GNT_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam int unsigned CNT_W = 16;

  logic [DRVRS-1:0]              pndng;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]              pop;
  logic [DRVRS-1:0]              push;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_push;
  logic [GNT_W-1:0]              grant;
  logic                          busy;
  logic [CNT_W-1:0]              drop_cnt;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, grant, busy, drop_cnt
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, grant, busy, drop_cnt
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the farthest offset down so the nearest requester overwrites.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = int'(N); off >= 1; off--) begin
      if (req_i[IW'((int'(ptr_i) + off) % int'(N))]) begin
        idx_o   = IW'((int'(ptr_i) + off) % int'(N));
        valid_o = 1'b1;
      end
    end
    gnt_oh_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// One-lane bus sequencer: round-robin pick a driver, pop its head packet,
// then push it to the addressed driver (or all others on broadcast).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned  pckg_sz   = 16,
  parameter int unsigned  drvrs     = 4,
  parameter logic [7:0]   broadcast = 8'hFF
) (
  input  logic         clock,
  input  logic         reset,
  bus_arbiter_if.master bus
);

  localparam int unsigned GW    = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam int unsigned CNT_W = 16;

  arb_state_t         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [pckg_sz-1:0] pkt_q, pkt_d;
  logic [drvrs-1:0]   pop_q, pop_d;
  logic [drvrs-1:0]   push_q, push_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [drvrs-1:0]   win_oh;
  logic [GW-1:0]      win_idx;
  logic               win_valid;
  logic [pckg_sz-1:0] head;
  logic [ID_W-1:0]    head_dest;
  logic [ID_W-1:0]    pkt_dest;
  logic               pkt_bad;

  rr_picker #(.N(drvrs)) u_picker (
    .req_i    (bus.pndng),
    .ptr_i    (ptr_q),
    .gnt_oh_o (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

  assign head      = bus.D_pop[grant_q];
  assign head_dest = get_dest(MAX_PKT_W'(head), pckg_sz);
  assign pkt_dest  = get_dest(MAX_PKT_W'(pkt_q), pckg_sz);
  assign pkt_bad   = (pkt_dest != broadcast) && (32'(pkt_dest) >= drvrs);

  // Next-state and registered-output decode; push vector is resolved in POP
  // from the live head so it lands together with the captured packet.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    pkt_d   = pkt_q;
    pop_d   = '0;
    push_d  = '0;
    busy_d  = 1'b0;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = POP;
          grant_d = win_idx;
          pop_d   = win_oh;
          busy_d  = 1'b1;
        end
      end
      POP: begin
        state_d = PUSH;
        pkt_d   = head;
        busy_d  = 1'b1;
        if (head_dest == broadcast) begin
          push_d = ~(drvrs'(1) << grant_q);
        end else if (32'(head_dest) < drvrs) begin
          push_d = drvrs'(1) << head_dest;
        end
      end
      PUSH: begin
        state_d = IDLE;
        ptr_d   = grant_q;
        if (pkt_bad && (drop_q != '1)) begin
          drop_d = drop_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(drvrs - 1);
      pkt_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      pkt_q   <= pkt_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.push     = push_q;
  assign bus.D_push   = {drvrs{pkt_q}};
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (4 drivers, 16-bit packets).
module tb_bus_arbiter;

  localparam int unsigned PW = 16;
  localparam int unsigned ND = 4;

  typedef struct {
    logic [ND-1:0] pop;
    logic [1:0]    grant;
    logic [ND-1:0] push;
    logic [PW-1:0] data;
    logic          busy;
    logic [15:0]   drop;
    int            gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bus_arbiter_if #(.PCKG_SZ(PW), .DRVRS(ND)) bus ();

  bus_arbiter #(.pckg_sz(PW), .drvrs(ND), .broadcast(8'hFF)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic add(input logic [ND-1:0] p, input logic [1:0] g, input logic [ND-1:0] pu,
                     input logic [PW-1:0] d, input logic b, input logic [15:0] dr, input int gap);
    exp_t e;
    e.pop = p; e.grant = g; e.push = pu; e.data = d; e.busy = b; e.drop = dr; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_pop(input logic [ND-1:0] m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((bus.pop & m) == '0) && (n < 40));
    chk("pop_seen", 64'((bus.pop & m) != '0), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each pop opens a transfer; push follows one cycle later, counter one after that.
  initial begin : monitor
    exp_t e;
    int   last_pop;
    last_pop = -100;
    forever begin
      @(negedge clk);
      if (bus.pop != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(bus.pop), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pop_vec", 64'(bus.pop), 64'(e.pop));
          chk("grant", 64'(bus.grant), 64'(e.grant));
          if (e.gap != 0) chk("grant_spacing", 64'(cyc - last_pop), 64'(e.gap));
          last_pop = cyc;
          @(negedge clk);
          chk("pop_width", 64'(bus.pop), 64'(0));
          chk("push_vec", 64'(bus.push), 64'(e.push));
          chk("busy_push", 64'(bus.busy), 64'(e.busy));
          if (e.push != '0) chk("push_data", 64'(bus.D_push), {4{e.data}});
          @(negedge clk);
          chk("drop_cnt", 64'(bus.drop_cnt), 64'(e.drop));
        end
      end else begin
        chk("stray_push", 64'(bus.push), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int n;
    rst_n     = 1'b0;
    bus.pndng = '0;
    bus.D_pop = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pop", 64'(bus.pop), 64'(0));
    chk("rst_push", 64'(bus.push), 64'(0));
    chk("rst_dpush", 64'(bus.D_push), 64'(0));
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_drop", 64'(bus.drop_cnt), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Fairness: all pending, everyone addresses driver 0.
    add(4'b0001, 2'd0, 4'b0001, 16'h00A0, 1'b1, 16'd0, 0);
    add(4'b0010, 2'd1, 4'b0001, 16'h00B1, 1'b1, 16'd0, 3);
    add(4'b0100, 2'd2, 4'b0001, 16'h00C2, 1'b1, 16'd0, 3);
    add(4'b1000, 2'd3, 4'b0001, 16'h00D3, 1'b1, 16'd0, 3);
    add(4'b0001, 2'd0, 4'b0001, 16'h00A0, 1'b1, 16'd0, 3);
    bus.D_pop[0] = 16'h00A0; bus.D_pop[1] = 16'h00B1;
    bus.D_pop[2] = 16'h00C2; bus.D_pop[3] = 16'h00D3;
    bus.pndng = 4'b1111;
    for (int k = 0; k < 5; k++) wait_pop(4'b1111);
    bus.pndng = '0;
    idle(4);

    // Single unicast 1 -> 3, with latency check.
    add(4'b0010, 2'd1, 4'b1000, 16'h03A5, 1'b1, 16'd0, 0);
    bus.D_pop[1] = 16'h03A5; bus.pndng = 4'b0010;
    t0 = cyc;
    wait_pop(4'b0010);
    chk("pop_latency", 64'(cyc - t0), 64'(1));
    bus.pndng = '0;
    idle(4);

    // Broadcast from driver 2.
    add(4'b0100, 2'd2, 4'b1011, 16'hFF42, 1'b1, 16'd0, 0);
    bus.D_pop[2] = 16'hFF42; bus.pndng = 4'b0100;
    wait_pop(4'b0100);
    bus.pndng = '0;
    idle(4);

    // Late request: driver 3 rises while driver 0 is being served.
    add(4'b0001, 2'd0, 4'b0100, 16'h0255, 1'b1, 16'd0, 0);
    add(4'b1000, 2'd3, 4'b0010, 16'h0133, 1'b1, 16'd0, 3);
    bus.D_pop[0] = 16'h0255; bus.pndng = 4'b0001;
    wait_pop(4'b0001);
    bus.D_pop[3] = 16'h0133; bus.pndng = 4'b1000;
    wait_pop(4'b1000);
    bus.pndng = '0;
    idle(4);

    // Invalid destination 7: dropped, counter 0 -> 1.
    add(4'b0001, 2'd0, 4'b0000, 16'h0000, 1'b1, 16'd1, 0);
    bus.D_pop[0] = 16'h0711; bus.pndng = 4'b0001;
    wait_pop(4'b0001);
    bus.pndng = '0;
    idle(4);

    // Reset during POP: transfer lost, then pointer restarts at driver 0.
    add(4'b0010, 2'd1, 4'b0000, 16'h0000, 1'b0, 16'd0, 0);
    bus.D_pop[0] = 16'h0188; bus.D_pop[1] = 16'h0077; bus.pndng = 4'b0011;
    wait_pop(4'b0010);
    rst_n = 1'b0;
    add(4'b0001, 2'd0, 4'b0010, 16'h0188, 1'b1, 16'd0, 0);
    add(4'b0010, 2'd1, 4'b0001, 16'h0077, 1'b1, 16'd0, 3);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_pop(4'b0001);
    bus.pndng = 4'b0010;
    wait_pop(4'b0010);
    bus.pndng = '0;
    idle(4);

    // Saturation: preload just below the ceiling, then two more drops.
    force dut.drop_q = 16'hFFFE;
    idle(1);
    release dut.drop_q;
    idle(1);
    add(4'b0100, 2'd2, 4'b0000, 16'h0000, 1'b1, 16'hFFFF, 0);
    bus.D_pop[2] = 16'h0500; bus.pndng = 4'b0100;
    wait_pop(4'b0100);
    bus.pndng = '0;
    idle(4);
    add(4'b0100, 2'd2, 4'b0000, 16'h0000, 1'b1, 16'hFFFF, 0);
    bus.D_pop[2] = 16'h0900; bus.pndng = 4'b0100;
    wait_pop(4'b0100);
    bus.pndng = '0;
    idle(4);

    n = 0;
    while ((exp_q.size() != 0) && (n < 50)) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
